// File: rtl/fscpu_pkg.sv
// Shared definitions for the motor command interface responders:
// motion state encoding and default pulse timing constants.
package fscpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } motor_state_t;

  // Clock cycles the step output is held high for every step
  localparam int unsigned C_PULSE_HIGH_DEF = 16;
  // Shortest allowed step period; must stay above the high time
  localparam int unsigned C_MIN_PERIOD_DEF = 32;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (limit switches,
// reset release). Output follows the input with two clock cycles of latency.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] meta_d;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_d;

  // Shift the raw input through the metastability and output stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer stages, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/step_motor_drv.sv
// Motor-side responder: turns start/stop/remain-modify commands into a
// step pulse train plus direction level, tracks position and limit
// switches, and reports motion status back to the controller.
module step_motor_drv
  import fscpu_pkg::*;
#(
  parameter int unsigned C_SPEED_DATA_WIDTH  = 32,
  parameter int unsigned C_STEP_NUMBER_WIDTH = 32,
  parameter int unsigned C_PULSE_HIGH        = C_PULSE_HIGH_DEF,
  parameter int unsigned C_MIN_PERIOD        = C_MIN_PERIOD_DEF
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           ctl_sel,
  input  logic                           ctl_start,
  input  logic                           ctl_stop,
  input  logic [C_SPEED_DATA_WIDTH-1:0]  ctl_speed,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] ctl_step,
  input  logic                           ctl_dir,
  input  logic                           ctl_mod_remain,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] ctl_new_remain,
  output logic                           ctl_state,
  output logic [C_SPEED_DATA_WIDTH-1:0]  ctl_rt_speed,
  output logic [C_STEP_NUMBER_WIDTH-1:0] ctl_position,
  output logic                           ctl_zpsign,
  output logic                           ctl_tpsign,
  input  logic                           i_zpd,
  input  logic                           i_tpd,
  output logic                           o_drive,
  output logic                           o_dir
);

  localparam int unsigned SW = C_SPEED_DATA_WIDTH;
  localparam int unsigned NW = C_STEP_NUMBER_WIDTH;
  localparam logic [SW-1:0] MIN_PERIOD_W = SW'(C_MIN_PERIOD);
  localparam logic [SW-1:0] PULSE_HIGH_W = SW'(C_PULSE_HIGH);

  logic         rst_n;
  logic [1:0]   limit_sync;
  logic         zp_sync;
  logic         tp_sync;

  motor_state_t state_q, state_d;
  logic [SW-1:0] period_q, period_d;
  logic [SW-1:0] phase_q, phase_d;
  logic [NW-1:0] remain_q, remain_d;
  logic [NW-1:0] position_q, position_d;
  logic          unlimited_q, unlimited_d;
  logic          dir_q, dir_d;
  logic          drive_q, drive_d;

  logic          boundary;
  logic          pulse_end;
  logic          limit_hit;

  // Reset asserts immediately but releases only on a clock edge
  sync_2ff #(.WIDTH(1)) u_rst_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d     (1'b1),
    .q     (rst_n)
  );

  sync_2ff #(.WIDTH(2)) u_limit_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({i_tpd, i_zpd}),
    .q     (limit_sync)
  );

  assign zp_sync = limit_sync[0];
  assign tp_sync = limit_sync[1];

  // phase_q counts down the cycles left in the current step period; a
  // boundary is the cycle it has run out. The pulse ends once PULSE_HIGH
  // cycles of the period have elapsed.
  assign boundary  = (phase_q == '0);
  assign pulse_end = drive_q && (phase_q == period_q - PULSE_HIGH_W);
  assign limit_hit = dir_q ? tp_sync : zp_sync;

  // Next-state, step scheduling and position tracking
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    phase_d     = phase_q;
    remain_d    = remain_q;
    unlimited_d = unlimited_q;
    dir_d       = dir_q;
    drive_d     = drive_q;
    position_d  = position_q;

    case (state_q)
      ST_IDLE: begin
        if (ctl_start && ctl_sel && !ctl_stop) begin
          state_d     = ST_RUN;
          period_d    = (ctl_speed < MIN_PERIOD_W) ? MIN_PERIOD_W : ctl_speed;
          remain_d    = ctl_step;
          unlimited_d = (ctl_step == '0);
          dir_d       = ctl_dir;
          phase_d     = '0;
          drive_d     = 1'b0;
        end
      end

      ST_RUN: begin
        if (!boundary) begin
          phase_d = phase_q - SW'(1);
        end
        if (pulse_end) begin
          drive_d = 1'b0;
        end
        if (ctl_stop) begin
          state_d = (drive_q && !pulse_end) ? ST_FINISH : ST_IDLE;
        end else if (boundary) begin
          if (limit_hit) begin
            state_d = ST_IDLE;
            if (!dir_q) begin
              position_d = '0;
            end
          end else if (!unlimited_q && remain_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            drive_d    = 1'b1;
            phase_d    = period_q - SW'(1);
            position_d = dir_q ? position_q + NW'(1) : position_q - NW'(1);
            if (!unlimited_q) begin
              remain_d = remain_q - NW'(1);
            end
          end
        end
        if (ctl_mod_remain) begin
          remain_d    = ctl_new_remain;
          unlimited_d = 1'b0;
        end
      end

      ST_FINISH: begin
        if (!boundary) begin
          phase_d = phase_q - SW'(1);
        end
        if (pulse_end || !drive_q) begin
          drive_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        drive_d = 1'b0;
      end
    endcase
  end

  // Motion registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      period_q    <= '0;
      phase_q     <= '0;
      remain_q    <= '0;
      unlimited_q <= 1'b0;
      dir_q       <= 1'b0;
      drive_q     <= 1'b0;
      position_q  <= '0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      phase_q     <= phase_d;
      remain_q    <= remain_d;
      unlimited_q <= unlimited_d;
      dir_q       <= dir_d;
      drive_q     <= drive_d;
      position_q  <= position_d;
    end
  end

  assign ctl_state    = (state_q != ST_IDLE);
  assign ctl_rt_speed = (state_q != ST_IDLE) ? period_q : '0;
  assign ctl_position = position_q;
  assign ctl_zpsign   = zp_sync;
  assign ctl_tpsign   = tp_sync;
  assign o_drive      = drive_q;
  assign o_dir        = dir_q;

endmodule
